dev_timer_multi: RTL and testbench
==================================

DEV_TIMER_MULTI -- requirements
Module: dev_timer_multi

Interface
REQ-001 Parameter CH_NUM, default 4, number of independent timer channels (power of two, 1..8).
REQ-002 Parameter CNT_W, default 32, counter/preset width (8..32); readback zero-extended to 32 bits.
REQ-003 Derived constant ADDR_W = log2(CH_NUM)+2, word-address width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 addr  input  ADDR_W  word address; upper bits = channel, lower 2 bits = register (0 CTRL, 1 PRESET, 2 COUNT, 3 STATUS).
REQ-007 we  input  1  write enable, sampled at rising edge.
REQ-008 wdata  input  32  write data.
REQ-009 rdata  output  32  combinational read data for addr.
REQ-010 irq_vec  output  CH_NUM  per-channel interrupt, pending AND IM.
REQ-011 int_request  output  1  OR of irq_vec.

Function
REQ-012 CTRL fields SHALL be: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as one-shot), [3] IM; other bits read 0.
REQ-013 PRESET SHALL be R/W, CNT_W bits; COUNT SHALL be read-only, writes ignored.
REQ-014 STATUS bit0 SHALL read the channel's pending flag; writing 1 to bit0 clears it, writing 0 has no effect.
REQ-015 Each channel SHALL run FSM IDLE, LOAD, CNT, INT.
REQ-016 IDLE->LOAD when EN=1; LOAD: count<=PRESET, ->CNT next cycle.
REQ-017 CNT: count>1 -> count-1; count<=1 -> count<=0, ->INT.
REQ-018 INT: pending<=1 (one cycle); MODE=01 ->LOAD; otherwise EN<=0, ->IDLE.
REQ-019 EN written 0 in any state SHALL force IDLE next cycle, count held, pending unchanged.
REQ-020 PRESET written during CNT SHALL take effect only at next LOAD.
REQ-021 PRESET=0 SHALL produce INT two cycles after LOAD (LOAD, CNT, INT).
REQ-022 Pending set and software clear in same cycle: set wins.
REQ-023 Channel index >= CH_NUM: not possible (power-of-two); register 3 writes affect only addressed channel.
REQ-024 Channels SHALL be fully independent; simultaneous expiries set each pending flag in the same cycle.

Reset
REQ-025 On reset low: all CTRL, PRESET, COUNT, pending = 0; FSM = IDLE; rdata reflects zeros; irq_vec = 0; int_request = 0.
REQ-026 Reset asserted mid-count SHALL abort immediately with no interrupt generated on release.

Configuration
REQ-027 Macro TIMER_PRESCALE_EN defined: CTRL[15:8] = PS, R/W; in CNT the count decrements once every PS+1 cycles via per-channel prescale counter cleared in LOAD.
REQ-028 Macro undefined: CTRL[15:8] reads 0, writes ignored; count decrements every cycle.

Structure
REQ-029 Package timer_pkg SHALL hold FSM state encoding, register offsets (CTRL/PRESET/COUNT/STATUS), MODE codes, CTRL bit positions.
REQ-030 One sub-module timer_channel SHALL implement a single channel (registers, FSM, prescaler); top instantiates CH_NUM copies and muxes rdata.

Verification
REQ-031 Ch0 PRESET=5, CTRL=0x9 (EN, one-shot, IM) -> irq_vec[0]=1 and int_request=1 in cycle 8 after the write; CTRL reads 0x8 afterwards; COUNT=0.
REQ-032 Ch1 PRESET=3, CTRL=0xB (auto-reload) -> pending set every 5 cycles; STATUS write 1 clears; pending re-sets on next expiry.
REQ-033 Ch2 counting from PRESET=100, write CTRL=0 at COUNT=60 -> FSM IDLE, COUNT holds 60, no interrupt.
REQ-034 Ch0 and ch3 both PRESET=4, enabled same cycle -> irq_vec=4'b1001 same cycle; IM=0 on ch3 -> irq_vec=4'b0001, STATUS ch3 still reads 1.
REQ-035 Reset pulsed low while ch0 COUNT=7 -> all registers 0, int_request=0, no interrupt after release.
REQ-036 With TIMER_PRESCALE_EN, PS=3, PRESET=2 -> expiry after 2x4 decrement cycles; without macro, CTRL[15:8] reads 0.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared encodings for dev_timer_multi -- channel FSM states,
// register offsets, MODE codes and CTRL bit positions.
package timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_e;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PRESET = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_MODE_LSB = 1;
   localparam int CTRL_IM_BIT   = 3;
   localparam int CTRL_PS_LSB   = 8;

endpackage

// File: rtl/timer_channel.sv
// timer_channel: one countdown channel (CTRL/PRESET/COUNT/STATUS, IDLE/LOAD/CNT/INT).
// Optional prescaler enabled by macro TIMER_PRESCALE_EN.
module timer_channel
   import timer_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_i,
   input  logic [1:0]  reg_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        irq_o
);

   state_e           state_q, state_d;
   logic             en_q, en_d;
   logic [1:0]       mode_q, mode_d;
   logic             im_q, im_d;
   logic [CNT_W-1:0] preset_q, preset_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             pending_q, pending_d;
   logic             ctrl_wr, stop_wr, tick;
   logic [31:0]      ctrl_rd;
   logic             unused_wdata;

   assign unused_wdata = ^wdata_i;

`ifdef TIMER_PRESCALE_EN
   logic [7:0] ps_q, ps_d, psc_q, psc_d;

   assign tick    = (psc_q == ps_q);
   assign ctrl_rd = {16'd0, ps_q, 4'd0, im_q, mode_q, en_q};

   always_comb begin
      psc_d = psc_q;
      ps_d  = ps_q;
      if (ctrl_wr) ps_d = wdata_i[CTRL_PS_LSB +: 8];
      if (!stop_wr) begin
         if (state_q == ST_LOAD)     psc_d = '0;
         else if (state_q == ST_CNT) psc_d = tick ? 8'd0 : psc_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ps_q  <= '0;
         psc_q <= '0;
      end else begin
         ps_q  <= ps_d;
         psc_q <= psc_d;
      end
   end
`else
   assign tick    = 1'b1;
   assign ctrl_rd = {28'd0, im_q, mode_q, en_q};
`endif

   always_comb begin
      ctrl_wr   = wr_i && (reg_i == REG_CTRL);
      stop_wr   = ctrl_wr && !wdata_i[CTRL_EN_BIT];
      state_d   = state_q;
      count_d   = count_q;
      en_d      = en_q;
      mode_d    = mode_q;
      im_d      = im_q;
      preset_d  = preset_q;
      pending_d = pending_q;

      case (state_q)
         ST_IDLE: if (en_q) state_d = ST_LOAD;
         ST_LOAD: begin
            count_d = preset_q;
            state_d = ST_CNT;
         end
         ST_CNT: if (tick) begin
            if (count_q > CNT_W'(1)) begin
               count_d = count_q - CNT_W'(1);
            end else begin
               count_d = '0;
               state_d = ST_INT;
            end
         end
         ST_INT: begin
            // MODE 1x falls through to one-shot behaviour
            if (mode_q == MODE_RELOAD) begin
               state_d = ST_LOAD;
            end else begin
               en_d    = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (wr_i && (reg_i == REG_PRESET)) preset_d = wdata_i[CNT_W-1:0];
      if (wr_i && (reg_i == REG_STATUS) && wdata_i[0]) pending_d = 1'b0;
      if (ctrl_wr) begin
         en_d   = wdata_i[CTRL_EN_BIT];
         mode_d = wdata_i[CTRL_MODE_LSB +: 2];
         im_d   = wdata_i[CTRL_IM_BIT];
      end
      // Software stop wins over the sequencer; the expiry set is applied after the clear
      if (stop_wr) begin
         state_d = ST_IDLE;
         count_d = count_q;
      end else if (state_q == ST_INT) begin
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         en_q      <= 1'b0;
         mode_q    <= MODE_ONESHOT;
         im_q      <= 1'b0;
         preset_q  <= '0;
         count_q   <= '0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         en_q      <= en_d;
         mode_q    <= mode_d;
         im_q      <= im_d;
         preset_q  <= preset_d;
         count_q   <= count_d;
         pending_q <= pending_d;
      end
   end

   always_comb begin
      case (reg_i)
         REG_CTRL:   rdata_o = ctrl_rd;
         REG_PRESET: rdata_o = 32'(preset_q);
         REG_COUNT:  rdata_o = 32'(count_q);
         default:    rdata_o = {31'd0, pending_q};
      endcase
   end

   assign irq_o = pending_q & im_q;

endmodule

// File: rtl/dev_timer_multi.sv
// dev_timer_multi: CH_NUM independent countdown timers behind a word-addressed register bus.
// Channel prescaler is built when macro TIMER_PRESCALE_EN is defined.
module dev_timer_multi
   import timer_pkg::*;
#(
   parameter  int CH_NUM = 4,
   parameter  int CNT_W  = 32,
   localparam int ADDR_W = $clog2(CH_NUM) + 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   input  logic              we,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic [CH_NUM-1:0] irq_vec,
   output logic              int_request
);

   localparam int SEL_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

   logic [SEL_W-1:0] ch_sel;
   logic [31:0]      ch_rdata [CH_NUM];

   generate
      if (CH_NUM > 1) begin : g_sel_multi
         assign ch_sel = addr[ADDR_W-1:2];
      end else begin : g_sel_single
         assign ch_sel = '0;
      end
   endgenerate

   for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
      timer_channel #(
         .CNT_W (CNT_W)
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .wr_i    (we && (ch_sel == SEL_W'(i))),
         .reg_i   (addr[1:0]),
         .wdata_i (wdata),
         .rdata_o (ch_rdata[i]),
         .irq_o   (irq_vec[i])
      );
   end

   assign rdata       = ch_rdata[ch_sel];
   assign int_request = |irq_vec;

endmodule

// File: tb/tb_dev_timer_multi.sv
// tb_dev_timer_multi: directed scenarios plus a randomized phase checked against
// an arithmetic expiry-schedule model of each channel.
module tb_dev_timer_multi;

   logic        clk;
   logic        reset;
   logic [3:0]  addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [3:0]  irq_vec;
   logic        int_request;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Model: each enabled channel expires at t0+3+L, then every L+2 edges if auto-reload
   bit m_act  [4];
   bit m_auto [4];
   bit m_im   [4];
   bit m_pend [4];
   int m_t0   [4];
   int m_p    [4];

   dev_timer_multi #(
      .CH_NUM (4),
      .CNT_W  (32)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .addr        (addr),
      .we          (we),
      .wdata       (wdata),
      .rdata       (rdata),
      .irq_vec     (irq_vec),
      .int_request (int_request)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int ch, input int r, input logic [31:0] d);
      addr  = 4'(ch * 4 + r);
      wdata = d;
      we    = 1'b1;
      tick();
      we    = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input int ch, input int r, input logic [31:0] exp);
      addr = 4'(ch * 4 + r);
      #1;
      chk(tag, rdata, exp);
   endtask

   function automatic bit expires(input int ch, input int n);
      int len, first;
      if (!m_act[ch]) return 1'b0;
      len   = (m_p[ch] == 0) ? 1 : m_p[ch];
      first = m_t0[ch] + 3 + len;
      if (n < first) return 1'b0;
      if (m_auto[ch]) return ((n - first) % (len + 2)) == 0;
      return n == first;
   endfunction

   task automatic rnd_cycle(input bit w, input int ch, input int r, input logic [31:0] d);
      logic [3:0] exp;
      addr  = 4'(ch * 4 + r);
      wdata = d;
      we    = w;
      tick();
      we    = 1'b0;
      if (w) begin
         if (r == 0 && d[0]) begin
            m_act[ch]  = 1'b1;
            m_t0[ch]   = cyc;
            m_auto[ch] = (d[2:1] == 2'b01);
            m_im[ch]   = d[3];
         end
         if (r == 1) m_p[ch] = int'(d);
         if (r == 3 && d[0]) m_pend[ch] = 1'b0;
      end
      exp = '0;
      for (int c = 0; c < 4; c++) begin
         if (expires(c, cyc)) m_pend[c] = 1'b1;
         exp[c] = m_pend[c] & m_im[c];
      end
      chk("rnd_irq", 32'(irq_vec), 32'(exp));
      chk("rnd_intreq", 32'(int_request), 32'(|exp));
   endtask

   initial begin
      reset = 1'b0;
      we    = 1'b0;
      addr  = '0;
      wdata = '0;
      ticks(2);

      chk("rst_irq", 32'(irq_vec), 32'h0);
      chk("rst_intreq", 32'(int_request), 32'h0);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            rd_chk("rst_reg", c, r, 32'h0);
      reset = 1'b1;
      tick();

      // One-shot on ch0
      wr(0, 1, 32'd5);
      wr(0, 0, 32'h9);
      ticks(7);
      chk("os_irq_early", 32'(irq_vec), 32'h0);
      tick();
      chk("os_irq", 32'(irq_vec), 32'h1);
      chk("os_intreq", 32'(int_request), 32'h1);
      rd_chk("os_ctrl", 0, 0, 32'h8);
      rd_chk("os_count", 0, 2, 32'h0);
      rd_chk("os_status", 0, 3, 32'h1);
      wr(0, 3, 32'h1);
      chk("os_clr", 32'(irq_vec), 32'h0);

      // Auto-reload on ch1, period 5
      wr(1, 1, 32'd3);
      wr(1, 0, 32'hB);
      ticks(5);
      chk("ar_early", 32'(irq_vec), 32'h0);
      tick();
      chk("ar_first", 32'(irq_vec), 32'h2);
      wr(1, 3, 32'h1);
      chk("ar_clr", 32'(irq_vec), 32'h0);
      ticks(3);
      chk("ar_gap", 32'(irq_vec), 32'h0);
      tick();
      chk("ar_second", 32'(irq_vec), 32'h2);
      wr(1, 3, 32'h1);
      ticks(3);
      chk("ar_gap2", 32'(irq_vec), 32'h0);
      tick();
      chk("ar_third", 32'(irq_vec), 32'h2);
      wr(1, 0, 32'h0);
      wr(1, 3, 32'h1);
      chk("ar_off", 32'(irq_vec), 32'h0);

      // Read-only COUNT, stop mid-count on ch2
      wr(2, 2, 32'h55);
      rd_chk("count_ro", 2, 2, 32'h0);
      wr(2, 1, 32'd100);
      rd_chk("preset_rb", 2, 1, 32'd100);
      wr(2, 0, 32'h9);
      ticks(42);
      rd_chk("stop_at60", 2, 2, 32'd60);
      wr(2, 0, 32'h0);
      ticks(5);
      rd_chk("stop_hold", 2, 2, 32'd60);
      ticks(80);
      chk("stop_noirq", 32'(irq_vec), 32'h0);
      rd_chk("stop_status", 2, 3, 32'h0);
      rd_chk("stop_hold2", 2, 2, 32'd60);

      // PRESET=0 on ch2: LOAD, CNT, INT
      wr(2, 1, 32'd0);
      wr(2, 0, 32'h9);
      ticks(3);
      chk("p0_early", 32'(irq_vec), 32'h0);
      tick();
      chk("p0_irq", 32'(irq_vec), 32'h4);
      wr(2, 3, 32'h1);

      // Simultaneous expiry on ch0 and ch3
      wr(0, 1, 32'd4);
      wr(3, 1, 32'd3);
      wr(0, 0, 32'h9);
      wr(3, 0, 32'h9);
      ticks(5);
      chk("sim_early", 32'(irq_vec), 32'h0);
      tick();
      chk("sim_both", 32'(irq_vec), 32'h9);
      wr(3, 0, 32'h0);
      chk("sim_mask3", 32'(irq_vec), 32'h1);
      rd_chk("sim_status3", 3, 3, 32'h1);
      wr(0, 3, 32'h1);
      wr(3, 3, 32'h1);
      chk("sim_clr", 32'(int_request), 32'h0);

      // Reset mid-count
      wr(0, 1, 32'd20);
      wr(0, 0, 32'h9);
      ticks(15);
      rd_chk("rm_count7", 0, 2, 32'd7);
      reset = 1'b0;
      #1;
      chk("rm_irq", 32'(irq_vec), 32'h0);
      rd_chk("rm_ctrl", 0, 0, 32'h0);
      rd_chk("rm_preset", 0, 1, 32'h0);
      rd_chk("rm_count", 0, 2, 32'h0);
      ticks(2);
      reset = 1'b1;
      ticks(30);
      chk("rm_post_irq", 32'(irq_vec), 32'h0);
      chk("rm_post_intreq", 32'(int_request), 32'h0);
      rd_chk("rm_post_status", 0, 3, 32'h0);

      // Prescaler field
`ifdef TIMER_PRESCALE_EN
      wr(1, 1, 32'd2);
      wr(1, 0, 32'h309);
      ticks(10);
      chk("ps_early", 32'(irq_vec), 32'h0);
      tick();
      chk("ps_irq", 32'(irq_vec), 32'h2);
      rd_chk("ps_ctrl", 1, 0, 32'h308);
`else
      wr(1, 0, 32'h300);
      rd_chk("ps_ignored", 1, 0, 32'h0);
      wr(1, 1, 32'd2);
      wr(1, 0, 32'h309);
      ticks(4);
      chk("ps_early", 32'(irq_vec), 32'h0);
      tick();
      chk("ps_irq", 32'(irq_vec), 32'h2);
      rd_chk("ps_ctrl", 1, 0, 32'h8);
`endif

      // Randomized phase against the schedule model
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      for (int c = 0; c < 4; c++) begin
         m_act[c] = 1'b0; m_auto[c] = 1'b0; m_im[c] = 1'b0;
         m_pend[c] = 1'b0; m_t0[c] = 0; m_p[c] = 0;
      end
      for (int c = 0; c < 4; c++) begin
         int gap;
         logic [31:0] ctl;
         gap = int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) rnd_cycle(1'b0, 0, 0, 32'h0);
         rnd_cycle(1'b1, c, 1, 32'($urandom_range(0, 9)));
         ctl = 32'h1 | (32'($urandom_range(0, 3)) << 1) | (32'($urandom_range(0, 1)) << 3);
         rnd_cycle(1'b1, c, 0, ctl);
      end
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 3) == 0)
            rnd_cycle(1'b1, int'($urandom_range(0, 3)), 3, 32'h1);
         else
            rnd_cycle(1'b0, 0, 0, 32'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
